// File: rtl/sincronizador_vga.sv
// VGA timing generator: pixel tick at half the system clock, horizontal and
// vertical counters, one-clock registered sync/visible decode and a
// frame-start pulse for the game-state update.
module sincronizador_vga #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  iColorRGB,
    output logic [10:0] pixelX,
    output logic [9:0]  pixelY,
    output logic        oHSync,
    output logic        oVSync,
    output logic [2:0]  oRGB,
    output logic        oVideoOn,
    output logic        oFrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        tick;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hs_n;
    logic        vs_n;
    logic        von;
    logic        line_end;
    logic        frame_end;

    // Pixel enable: toggles every clock so each pixel spans two clocks
    always_ff @(posedge clk) begin
        if (reset) tick <= 1'b0;
        else       tick <= ~tick;
    end

    assign line_end  = (hcount == H_LAST);
    assign frame_end = line_end && (vcount == V_LAST);

    // Horizontal/vertical position counters, advanced on pixel ticks only
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            if (line_end) begin
                hcount <= '0;
                if (vcount == V_LAST) vcount <= '0;
                else                  vcount <= vcount + 10'd1;
            end else begin
                hcount <= hcount + 11'd1;
            end
        end
    end

    // Sync and visible-area decode straight from the counters
    always_comb begin
        hs_n = ~((hcount >= H_SYNC_BEG) && (hcount <= H_SYNC_END));
        vs_n = ~((vcount >= V_SYNC_BEG) && (vcount <= V_SYNC_END));
        von  = (hcount < H_VIS_END) && (vcount < V_VIS_END);
    end

    // Register the decode once so it lines up with the painter's colour
    always_ff @(posedge clk) begin
        if (reset) begin
            oHSync      <= 1'b1;
            oVSync      <= 1'b1;
            oVideoOn    <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oHSync      <= hs_n;
            oVSync      <= vs_n;
            oVideoOn    <= von;
            oFrameStart <= tick && frame_end;
        end
    end

    assign pixelX = hcount;
    assign pixelY = vcount;
    assign oRGB   = oVideoOn ? iColorRGB : 3'd0;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Bench for sincronizador_vga with a shrunk timing set so several whole
// frames fit in a short run. Expected outputs come from a clock-count model
// (pixel index = clocks since reset / 2), queued at each edge and compared
// at the following falling edge.
module tb_sincronizador_vga;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FP = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  iColorRGB = 3'd0;
    logic [10:0] pixelX;
    logic [9:0]  pixelY;
    logic        oHSync, oVSync, oVideoOn, oFrameStart;
    logic [2:0]  oRGB;

    sincronizador_vga #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .iColorRGB(iColorRGB),
        .pixelX(pixelX), .pixelY(pixelY), .oHSync(oHSync), .oVSync(oVSync),
        .oRGB(oRGB), .oVideoOn(oVideoOn), .oFrameStart(oFrameStart)
    );

    always #10 clk = ~clk;

    typedef struct {
        int x;
        int y;
        logic hs;
        logic vs;
        logic von;
        logic fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    int   mx = 0, my = 0;
    int   cyc = 0;
    int   hs_run = 0, vs_run = 0, last_fs = -1;
    int   fs_seen = 0;

    function automatic exp_t model(int cnt);
        exp_t e;
        int p, pp, hx, hy;
        p   = (cnt / 2) % FP;
        e.x = p % HT;
        e.y = p / HT;
        if (cnt == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.fs = 1'b0;
        end else begin
            pp = ((cnt - 1) / 2) % FP;
            hx = pp % HT;
            hy = pp / HT;
            e.hs  = !(hx >= HV + HF && hx < HV + HF + HS);
            e.vs  = !(hy >= VV + VF && hy < VV + VF + VS);
            e.von = (hx < HV) && (hy < VV);
            e.fs  = (cnt % (2 * FP)) == 0;
        end
        return e;
    endfunction

    task automatic chk(string tag, int obs, int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: model the edge, queue expectation, compare at the falling edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        if (reset) n = 0;
        else       n = n + 1;
        exp_q.push_back(model(n));
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("queue_empty", 0, 1);
            return;
        end
        e  = exp_q.pop_front();
        mx = e.x;
        my = e.y;
        chk("pixelX", int'(pixelX), e.x);
        chk("pixelY", int'(pixelY), e.y);
        chk("oHSync", int'(oHSync), int'(e.hs));
        chk("oVSync", int'(oVSync), int'(e.vs));
        chk("oVideoOn", int'(oVideoOn), int'(e.von));
        chk("oFrameStart", int'(oFrameStart), int'(e.fs));
        chk("oRGB", int'(oRGB), e.von ? int'(iColorRGB) : 0);

        if (!oHSync) hs_run++;
        else begin
            if (hs_run != 0) chk("hsync_low_len", hs_run, 2 * HS);
            hs_run = 0;
        end
        if (!oVSync) vs_run++;
        else begin
            if (vs_run != 0) chk("vsync_low_len", vs_run, 2 * HT * VS);
            vs_run = 0;
        end
        if (reset) last_fs = -1;
        if (oFrameStart) begin
            fs_seen++;
            if (last_fs >= 0) chk("frame_spacing", cyc - last_fs, 2 * FP);
            last_fs = cyc;
        end
    endtask

    task automatic reset_at(int tx, int ty, logic want_tick);
        int guard = 0;
        while (!(mx == tx && my == ty && logic'(n % 2) == want_tick) && guard < 4 * FP) begin
            iColorRGB = 3'($urandom_range(7));
            step();
            guard++;
        end
        chk("reset_target_reached", int'(guard < 4 * FP), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_pixelX", int'(pixelX), 0);
        chk("rst_pixelY", int'(pixelY), 0);
        chk("rst_oHSync", int'(oHSync), 1);
        chk("rst_oVSync", int'(oVSync), 1);
        chk("rst_oVideoOn", int'(oVideoOn), 0);
        chk("rst_oFrameStart", int'(oFrameStart), 0);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_oRGB", int'(oRGB), 0);
        reset = 1'b0;
        iColorRGB = 3'd7;

        step();
        chk("first_clk_pixelX", int'(pixelX), 0);
        step();
        chk("second_clk_pixelX", int'(pixelX), 1);

        for (int i = 0; i < 2 * HT - 2; i++) step();
        chk("line1_pixelY", int'(pixelY), 1);
        chk("line1_pixelX", int'(pixelX), 0);

        for (int i = 0; i < 2 * FP; i++) step();
        for (int i = 0; i < 2 * FP + 20; i++) begin
            iColorRGB = 3'($urandom_range(7));
            step();
        end
        chk("frame_starts_seen", fs_seen, 2);

        reset_at(HV / 2 + 3, VV / 2, 1'b1);
        reset_at(HV / 2 + 2, VV / 2 - 1, 1'b0);

        for (int i = 0; i < 2 * FP + 10; i++) begin
            iColorRGB = 3'($urandom_range(7));
            step();
        end
        chk("frame_starts_total", fs_seen, 3);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
